// File: rtl/lpc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lpc_pkg
// Description : Shared constants for the LPC frame packer: frame geometry,
//               CSR address map, FSM state encoding and the word-select
//               helper used to serialise a captured frame.
// Revision    : 1.0 - initial release
// ============================================================================
package lpc_pkg;

    localparam int FRAME_WORDS = 13;
    localparam int FRAME_BITS  = FRAME_WORDS * 16;

    // CSR address map
    localparam logic [2:0] CSR_BASE   = 3'd0;
    localparam logic [2:0] CSR_LIMIT  = 3'd1;
    localparam logic [2:0] CSR_STEP   = 3'd2;
    localparam logic [2:0] CSR_RSVD   = 3'd3;
    localparam logic [2:0] CSR_START  = 3'd4;
    localparam logic [2:0] CSR_STATUS = 3'd5;
    localparam logic [2:0] CSR_SRST   = 3'd6;
    localparam logic [2:0] CSR_OVF    = 3'd7;

    // Packer FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // A frame is held packed with word 0 in the least significant slot.
    function automatic logic [15:0] frame_word(input logic [FRAME_BITS-1:0] frame,
                                               input logic [3:0]            idx);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < FRAME_WORDS; i++) begin
            if (idx == 4'(i)) begin
                w = frame[i*16 +: 16];
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lpc_frame_packer_csr.sv
`default_nettype none
// ============================================================================
// Module      : lpc_frame_packer_csr
// Description : Avalon-MM CSR slave for the LPC frame packer. Holds the base,
//               frame-limit and step registers, produces single-cycle start
//               and soft-reset pulses, and returns registered read data.
// Ports       : clk/rst            - clock, synchronous active-high reset
//               addr/read/write/writedata/readdata - Avalon-MM CSR slave
//               i_busy/i_done      - packer status
//               i_ovf_count        - dropped-frame counter
//               o_base/o_limit/o_step - configuration
//               o_start/o_soft_rst - command pulses, valid in the strobe cycle
// Revision    : 1.0 - initial release
// ============================================================================
module lpc_frame_packer_csr
    import lpc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  addr,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    input  logic        i_busy,
    input  logic        i_done,
    input  logic [15:0] i_ovf_count,
    output logic [15:0] o_base,
    output logic [15:0] o_limit,
    output logic [15:0] o_step,
    output logic        o_start,
    output logic        o_soft_rst
);

    logic [15:0] r_base;
    logic [15:0] r_limit;
    logic [15:0] r_step;
    logic [15:0] r_readdata;
    logic [15:0] w_rd_mux;

    // Commands act on the same edge as the write strobe, so they are
    // decoded combinationally rather than registered.
    assign o_start    = write && (addr == CSR_START) && writedata[0];
    assign o_soft_rst = write && (addr == CSR_SRST)  && writedata[0];

    always_comb begin
        w_rd_mux = '0;
        case (addr)
            CSR_BASE:   w_rd_mux = r_base;
            CSR_LIMIT:  w_rd_mux = r_limit;
            CSR_STEP:   w_rd_mux = r_step;
            CSR_STATUS: w_rd_mux = {14'd0, i_done, i_busy};
            CSR_OVF:    w_rd_mux = i_ovf_count;
            default:    w_rd_mux = '0;
        endcase
    end

    // Soft reset intentionally leaves the configuration registers intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base     <= '0;
            r_limit    <= '0;
            r_step     <= '0;
            r_readdata <= '0;
        end else begin
            if (write) begin
                case (addr)
                    CSR_BASE:  r_base  <= writedata;
                    CSR_LIMIT: r_limit <= writedata;
                    CSR_STEP:  r_step  <= writedata;
                    default: ;
                endcase
            end
            if (read) begin
                r_readdata <= w_rd_mux;
            end
        end
    end

    assign o_base   = r_base;
    assign o_limit  = r_limit;
    assign o_step   = r_step;
    assign readdata = r_readdata;

endmodule
`default_nettype wire

// File: rtl/lpc_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : lpc_frame_packer
// Description : Captures completed LPC frames on the encoder frame-valid
//               pulse and streams each one as 13 16-bit words to DDR through
//               an Avalon-MM write master. A one-deep pending buffer feeds a
//               working register so consecutive frames stream without a gap.
// Ports       : clk/rst                  - clock, synchronous active-high reset
//               A0..A10/voiced/freq_count/v - frame from the encoder
//               ddr_*                    - Avalon-MM write master
//               addr/read/write/writedata/readdata - Avalon-MM CSR slave
// Revision    : 1.0 - initial release
// ============================================================================
module lpc_frame_packer
    import lpc_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [15:0]  A0,
    input  logic signed [15:0]  A1,
    input  logic signed [15:0]  A2,
    input  logic signed [15:0]  A3,
    input  logic signed [15:0]  A4,
    input  logic signed [15:0]  A5,
    input  logic signed [15:0]  A6,
    input  logic signed [15:0]  A7,
    input  logic signed [15:0]  A8,
    input  logic signed [15:0]  A9,
    input  logic signed [15:0]  A10,
    input  logic                voiced,
    input  logic [15:0]         freq_count,
    input  logic                v,
    input  logic                ddr_waitrequest,
    output logic [ADDR_W-1:0]   ddr_addr,
    output logic                ddr_write,
    output logic [15:0]         ddr_writedata,
    input  logic [2:0]          addr,
    input  logic                read,
    input  logic                write,
    input  logic [15:0]         writedata,
    output logic [15:0]         readdata
);

    logic [1:0]            r_state;
    logic [1:0]            w_state_d;
    logic                  r_pend_valid;
    logic [FRAME_BITS-1:0] r_pend;
    logic [FRAME_BITS-1:0] r_work;
    logic [3:0]            r_word;
    logic [ADDR_W-1:0]     r_offset;
    logic [15:0]           r_frames;
    logic [15:0]           r_ovf;

    logic [FRAME_BITS-1:0] w_frame_in;
    logic [15:0]           w_base;
    logic [15:0]           w_limit;
    logic [15:0]           w_step;
    logic                  w_start;
    logic                  w_soft_rst;
    logic                  w_busy;
    logic                  w_accept;
    logic                  w_last_word;
    logic [15:0]           w_frames_next;
    logic                  w_promote;
    logic                  w_arm;
    logic                  w_capture;
    logic                  w_drop;

    lpc_frame_packer_csr u_csr (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .readdata    (readdata),
        .i_busy      (w_busy),
        .i_done      (r_state == ST_DONE),
        .i_ovf_count (r_ovf),
        .o_base      (w_base),
        .o_limit     (w_limit),
        .o_step      (w_step),
        .o_start     (w_start),
        .o_soft_rst  (w_soft_rst)
    );

    assign w_frame_in = {A10, A9, A8, A7, A6, A5, A4, A3, A2, A1, A0,
                         15'd0, voiced, freq_count};

    assign w_busy        = (r_state == ST_ARMED) || (r_state == ST_WRITE);
    assign w_accept      = (r_state == ST_WRITE) && !ddr_waitrequest;
    assign w_last_word   = w_accept && (r_word == 4'(FRAME_WORDS - 1));
    assign w_frames_next = r_frames + 16'd1;

    always_comb begin
        w_state_d = r_state;
        w_promote = 1'b0;
        w_arm     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start) begin
                    w_arm     = 1'b1;
                    w_state_d = (w_limit == 16'd0) ? ST_DONE : ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (r_pend_valid) begin
                    w_promote = 1'b1;
                    w_state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_last_word) begin
                    if (w_frames_next == w_limit) begin
                        w_state_d = ST_DONE;
                    end else if (r_pend_valid) begin
                        // Next frame already waiting: swap it in on the
                        // same edge so the stream has no bubble.
                        w_promote = 1'b1;
                    end else begin
                        w_state_d = ST_ARMED;
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // The pending slot may be refilled on the edge it is being emptied.
    assign w_capture = v && w_busy && (!r_pend_valid || w_promote);
    assign w_drop    = v && w_busy && !w_capture;

    always_ff @(posedge clk) begin
        if (rst || w_soft_rst) begin
            r_state      <= ST_IDLE;
            r_pend_valid <= 1'b0;
            r_pend       <= '0;
            r_work       <= '0;
            r_word       <= '0;
            r_offset     <= '0;
            r_frames     <= '0;
            r_ovf        <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_arm) begin
                r_pend_valid <= 1'b0;
                r_word       <= '0;
                r_offset     <= '0;
                r_frames     <= '0;
            end else begin
                if (w_promote) begin
                    r_work <= r_pend;
                end
                if (w_capture) begin
                    r_pend       <= w_frame_in;
                    r_pend_valid <= 1'b1;
                end else if (w_promote) begin
                    r_pend_valid <= 1'b0;
                end
                // Offset accumulates step per word, so it equals
                // widx*step modulo the address space without a multiplier.
                if (w_accept) begin
                    r_offset <= r_offset + ADDR_W'(w_step);
                    r_word   <= w_last_word ? 4'd0 : r_word + 4'd1;
                end
                if (w_last_word) begin
                    r_frames <= w_frames_next;
                end
                if (w_drop && (r_ovf != 16'hFFFF)) begin
                    r_ovf <= r_ovf + 16'd1;
                end
            end
        end
    end

    assign ddr_write     = (r_state == ST_WRITE);
    assign ddr_addr      = ADDR_W'(w_base) + r_offset;
    assign ddr_writedata = frame_word(r_work, r_word);

endmodule
`default_nettype wire

// File: tb/tb_lpc_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lpc_frame_packer
// Description : Directed self-checking testbench for lpc_frame_packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lpc_frame_packer;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] A0, A1, A2, A3, A4, A5, A6, A7, A8, A9, A10;
    logic               voiced;
    logic [15:0]        freq_count;
    logic               v;
    logic               ddr_waitrequest;
    logic [15:0]        ddr_addr;
    logic               ddr_write;
    logic [15:0]        ddr_writedata;
    logic [2:0]         addr;
    logic               read;
    logic               write;
    logic [15:0]        writedata;
    logic [15:0]        readdata;

    int vectors     = 0;
    int miscompares = 0;

    // Stimulus frames
    logic [15:0] fr_a     [0:3][0:10];
    logic [15:0] fr_freq  [0:3];
    logic        fr_voiced[0:3];

    // Monitor state (written only by the monitor process)
    logic [15:0] mon_addr[$];
    logic [15:0] mon_data[$];
    int          mon_cyc[$];
    int          write_cycles = 0;
    int          unstable     = 0;
    int          stall_events = 0;
    bit          stall_en     = 1'b0;

    lpc_frame_packer #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .A0(A0), .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5),
        .A6(A6), .A7(A7), .A8(A8), .A9(A9), .A10(A10),
        .voiced(voiced), .freq_count(freq_count), .v(v),
        .ddr_waitrequest(ddr_waitrequest), .ddr_addr(ddr_addr),
        .ddr_write(ddr_write), .ddr_writedata(ddr_writedata),
        .addr(addr), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_word(input int k, input int j);
        if (j == 0) return fr_freq[k];
        if (j == 1) return {15'd0, fr_voiced[k]};
        return fr_a[k][j-2];
    endfunction

    // Bus monitor and stall generator, sampling on the falling edge.
    // Accepted words are recorded; with stall_en, every other word is held
    // off by three cycles of waitrequest and checked for stability.
    initial begin
        int          cyc;
        int          stall_left;
        int          word_cnt;
        logic [15:0] held_addr;
        logic [15:0] held_data;
        cyc = 0; stall_left = 0; word_cnt = 0;
        held_addr = '0; held_data = '0;
        ddr_waitrequest = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (ddr_write === 1'b1) begin
                write_cycles++;
                if (ddr_waitrequest) begin
                    if (ddr_addr !== held_addr || ddr_writedata !== held_data) unstable++;
                    stall_left--;
                    if (stall_left == 0) begin
                        ddr_waitrequest = 1'b0;
                        mon_addr.push_back(ddr_addr);
                        mon_data.push_back(ddr_writedata);
                        mon_cyc.push_back(cyc);
                        word_cnt++;
                    end
                end else if (stall_en && (word_cnt % 2 == 0)) begin
                    ddr_waitrequest = 1'b1;
                    stall_left      = 3;
                    held_addr       = ddr_addr;
                    held_data       = ddr_writedata;
                    stall_events++;
                end else begin
                    mon_addr.push_back(ddr_addr);
                    mon_data.push_back(ddr_writedata);
                    mon_cyc.push_back(cyc);
                    word_cnt++;
                end
            end
        end
    end

    task automatic csr_write(input logic [2:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        addr = a; writedata = d; write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [15:0] d);
        @(posedge clk); #1;
        addr = a; read = 1'b1;
        @(posedge clk); #1;
        read = 1'b0;
        d = readdata;
    endtask

    task automatic send_frame(input int k);
        @(posedge clk); #1;
        A0 = fr_a[k][0]; A1 = fr_a[k][1]; A2 = fr_a[k][2]; A3 = fr_a[k][3];
        A4 = fr_a[k][4]; A5 = fr_a[k][5]; A6 = fr_a[k][6]; A7 = fr_a[k][7];
        A8 = fr_a[k][8]; A9 = fr_a[k][9]; A10 = fr_a[k][10];
        voiced = fr_voiced[k]; freq_count = fr_freq[k]; v = 1'b1;
        @(posedge clk); #1;
        v = 1'b0;
    endtask

    task automatic wait_accepts(input int target, input int budget, output bit ok);
        int n;
        n = 0;
        while (mon_addr.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (mon_addr.size() >= target);
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        vectors++; if (ddr_write !== 1'b0) begin miscompares++; $display("FAIL rst_write: got %b exp 0", ddr_write); end
        vectors++; if (ddr_addr !== 16'h0) begin miscompares++; $display("FAIL rst_addr: got %h exp 0000", ddr_addr); end
        vectors++; if (ddr_writedata !== 16'h0) begin miscompares++; $display("FAIL rst_wdata: got %h exp 0000", ddr_writedata); end
        vectors++; if (readdata !== 16'h0) begin miscompares++; $display("FAIL rst_readdata: got %h exp 0000", readdata); end
        csr_read(3'd5, rd);
        vectors++; if (rd !== 16'h0) begin miscompares++; $display("FAIL rst_status: got %h exp 0000", rd); end
        csr_read(3'd7, rd);
        vectors++; if (rd !== 16'h0) begin miscompares++; $display("FAIL rst_ovf: got %h exp 0000", rd); end
        csr_read(3'd0, rd);
        vectors++; if (rd !== 16'h0) begin miscompares++; $display("FAIL rst_base: got %h exp 0000", rd); end
    endtask

    task automatic test_basic();
        int b0, wc0;
        bit ok;
        logic [15:0] rd, ea;
        csr_write(3'd0, 16'h0100);
        csr_write(3'd2, 16'h0001);
        csr_write(3'd1, 16'h0002);
        csr_write(3'd4, 16'h0001);
        b0 = mon_addr.size(); wc0 = write_cycles;
        send_frame(0);
        vectors++; if (ddr_write !== 1'b0) begin miscompares++; $display("FAIL basic_lat_t: got %b exp 0", ddr_write); end
        @(posedge clk); #1;
        vectors++; if (ddr_write !== 1'b1) begin miscompares++; $display("FAIL basic_lat_t1: got %b exp 1", ddr_write); end
        repeat (237) @(posedge clk);
        send_frame(1);
        wait_accepts(b0 + 26, 200, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL basic_timeout: got %0d words exp 26", mon_addr.size() - b0); end
        repeat (5) @(posedge clk); #1;
        vectors++; if (mon_addr.size() != b0 + 26) begin miscompares++; $display("FAIL basic_count: got %0d exp 26", mon_addr.size() - b0); end
        vectors++; if (write_cycles - wc0 != 26) begin miscompares++; $display("FAIL basic_wcycles: got %0d exp 26", write_cycles - wc0); end
        for (int j = 0; j < 26 && b0 + j < mon_addr.size(); j++) begin
            ea = 16'(32'h0100 + j);
            vectors++; if (mon_addr[b0+j] !== ea) begin miscompares++; $display("FAIL basic_addr[%0d]: got %h exp %h", j, mon_addr[b0+j], ea); end
            vectors++; if (mon_data[b0+j] !== exp_word(j / 13, j % 13)) begin miscompares++; $display("FAIL basic_data[%0d]: got %h exp %h", j, mon_data[b0+j], exp_word(j / 13, j % 13)); end
        end
        csr_read(3'd5, rd);
        vectors++; if (rd !== 16'h0002) begin miscompares++; $display("FAIL basic_status: got %h exp 0002", rd); end
        csr_read(3'd7, rd);
        vectors++; if (rd !== 16'h0000) begin miscompares++; $display("FAIL basic_ovf: got %h exp 0000", rd); end
    endtask

    task automatic test_stall();
        int b0, wc0, u0, s0;
        bit ok;
        logic [15:0] ea;
        b0 = mon_addr.size(); wc0 = write_cycles; u0 = unstable; s0 = stall_events;
        stall_en = 1'b1;
        csr_write(3'd4, 16'h0001);
        send_frame(0);
        repeat (238) @(posedge clk);
        send_frame(1);
        wait_accepts(b0 + 26, 300, ok);
        stall_en = 1'b0;
        vectors++; if (!ok) begin miscompares++; $display("FAIL stall_timeout: got %0d words exp 26", mon_addr.size() - b0); end
        repeat (5) @(posedge clk); #1;
        for (int j = 0; j < 26 && b0 + j < mon_addr.size(); j++) begin
            ea = 16'(32'h0100 + j);
            vectors++; if (mon_addr[b0+j] !== ea) begin miscompares++; $display("FAIL stall_addr[%0d]: got %h exp %h", j, mon_addr[b0+j], ea); end
            vectors++; if (mon_data[b0+j] !== exp_word(j / 13, j % 13)) begin miscompares++; $display("FAIL stall_data[%0d]: got %h exp %h", j, mon_data[b0+j], exp_word(j / 13, j % 13)); end
        end
        vectors++; if (unstable != u0) begin miscompares++; $display("FAIL stall_stable: got %0d changes exp 0", unstable - u0); end
        vectors++; if (stall_events - s0 != 13) begin miscompares++; $display("FAIL stall_events: got %0d exp 13", stall_events - s0); end
        vectors++; if (write_cycles - wc0 != 65) begin miscompares++; $display("FAIL stall_wcycles: got %0d exp 65", write_cycles - wc0); end
    endtask

    task automatic test_overflow();
        int b0, wc0, k;
        bit ok;
        logic [15:0] rd, ea;
        csr_write(3'd6, 16'h0001);
        csr_write(3'd0, 16'h0200);
        csr_write(3'd1, 16'h0003);
        csr_write(3'd4, 16'h0001);
        b0 = mon_addr.size(); wc0 = write_cycles;
        send_frame(0);
        send_frame(1);
        send_frame(2);
        wait_accepts(b0 + 26, 100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL ovf_timeout1: got %0d words exp 26", mon_addr.size() - b0); end
        repeat (10) @(posedge clk); #1;
        vectors++; if (mon_addr.size() != b0 + 26) begin miscompares++; $display("FAIL ovf_dropped: got %0d words exp 26", mon_addr.size() - b0); end
        if (mon_cyc.size() >= b0 + 14) begin
            vectors++; if (mon_cyc[b0+13] - mon_cyc[b0+12] != 1) begin miscompares++; $display("FAIL ovf_bubble: got gap %0d exp 1", mon_cyc[b0+13] - mon_cyc[b0+12]); end
        end
        csr_read(3'd5, rd);
        vectors++; if (rd !== 16'h0001) begin miscompares++; $display("FAIL ovf_status_busy: got %h exp 0001", rd); end
        csr_read(3'd7, rd);
        vectors++; if (rd !== 16'h0001) begin miscompares++; $display("FAIL ovf_count: got %h exp 0001", rd); end
        send_frame(3);
        wait_accepts(b0 + 39, 100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL ovf_timeout2: got %0d words exp 39", mon_addr.size() - b0); end
        repeat (3) @(posedge clk); #1;
        for (int j = 0; j < 39 && b0 + j < mon_addr.size(); j++) begin
            k  = (j < 26) ? j / 13 : 3;
            ea = 16'(32'h0200 + j);
            vectors++; if (mon_addr[b0+j] !== ea) begin miscompares++; $display("FAIL ovf_addr[%0d]: got %h exp %h", j, mon_addr[b0+j], ea); end
            vectors++; if (mon_data[b0+j] !== exp_word(k, j % 13)) begin miscompares++; $display("FAIL ovf_data[%0d]: got %h exp %h", j, mon_data[b0+j], exp_word(k, j % 13)); end
        end
        vectors++; if (write_cycles - wc0 != 39) begin miscompares++; $display("FAIL ovf_wcycles: got %0d exp 39", write_cycles - wc0); end
        csr_read(3'd5, rd);
        vectors++; if (rd !== 16'h0002) begin miscompares++; $display("FAIL ovf_status_done: got %h exp 0002", rd); end
    endtask

    task automatic test_wrap();
        int b0;
        bit ok;
        logic [15:0] rd, ea;
        csr_write(3'd0, 16'hFFF8);
        csr_write(3'd2, 16'h0002);
        csr_write(3'd1, 16'h0001);
        csr_write(3'd4, 16'h0001);
        b0 = mon_addr.size();
        send_frame(2);
        wait_accepts(b0 + 13, 100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL wrap_timeout: got %0d words exp 13", mon_addr.size() - b0); end
        repeat (3) @(posedge clk); #1;
        for (int j = 0; j < 13 && b0 + j < mon_addr.size(); j++) begin
            ea = 16'(32'hFFF8 + 2 * j);
            vectors++; if (mon_addr[b0+j] !== ea) begin miscompares++; $display("FAIL wrap_addr[%0d]: got %h exp %h", j, mon_addr[b0+j], ea); end
            vectors++; if (mon_data[b0+j] !== exp_word(2, j)) begin miscompares++; $display("FAIL wrap_data[%0d]: got %h exp %h", j, mon_data[b0+j], exp_word(2, j)); end
        end
        csr_read(3'd5, rd);
        vectors++; if (rd !== 16'h0002) begin miscompares++; $display("FAIL wrap_status: got %h exp 0002", rd); end
    endtask

    task automatic test_soft_reset();
        int b0, wc0;
        bit ok;
        logic [15:0] rd, ea;
        csr_read(3'd7, rd);
        vectors++; if (rd !== 16'h0001) begin miscompares++; $display("FAIL srst_ovf_before: got %h exp 0001", rd); end
        csr_write(3'd0, 16'h0300);
        csr_write(3'd2, 16'h0001);
        csr_write(3'd1, 16'h0001);
        csr_write(3'd4, 16'h0001);
        b0 = mon_addr.size();
        send_frame(1);
        wait_accepts(b0 + 6, 100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL srst_timeout1: got %0d words exp 6", mon_addr.size() - b0); end
        csr_write(3'd6, 16'h0001);
        vectors++; if (ddr_write !== 1'b0) begin miscompares++; $display("FAIL srst_write_drop: got %b exp 0", ddr_write); end
        wc0 = write_cycles;
        csr_read(3'd5, rd);
        vectors++; if (rd !== 16'h0000) begin miscompares++; $display("FAIL srst_status: got %h exp 0000", rd); end
        csr_read(3'd0, rd);
        vectors++; if (rd !== 16'h0300) begin miscompares++; $display("FAIL srst_base: got %h exp 0300", rd); end
        csr_read(3'd2, rd);
        vectors++; if (rd !== 16'h0001) begin miscompares++; $display("FAIL srst_step: got %h exp 0001", rd); end
        csr_read(3'd1, rd);
        vectors++; if (rd !== 16'h0001) begin miscompares++; $display("FAIL srst_limit: got %h exp 0001", rd); end
        csr_read(3'd7, rd);
        vectors++; if (rd !== 16'h0000) begin miscompares++; $display("FAIL srst_ovf_after: got %h exp 0000", rd); end
        vectors++; if (write_cycles != wc0) begin miscompares++; $display("FAIL srst_quiet: got %0d write cycles exp 0", write_cycles - wc0); end
        csr_write(3'd4, 16'h0001);
        b0 = mon_addr.size();
        send_frame(3);
        wait_accepts(b0 + 13, 100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL srst_timeout2: got %0d words exp 13", mon_addr.size() - b0); end
        repeat (3) @(posedge clk); #1;
        for (int j = 0; j < 13 && b0 + j < mon_addr.size(); j++) begin
            ea = 16'(32'h0300 + j);
            vectors++; if (mon_addr[b0+j] !== ea) begin miscompares++; $display("FAIL srst_addr[%0d]: got %h exp %h", j, mon_addr[b0+j], ea); end
            vectors++; if (mon_data[b0+j] !== exp_word(3, j)) begin miscompares++; $display("FAIL srst_data[%0d]: got %h exp %h", j, mon_data[b0+j], exp_word(3, j)); end
        end
    endtask

    task automatic test_zero_limit();
        int wc0;
        logic [15:0] rd;
        csr_write(3'd1, 16'h0000);
        wc0 = write_cycles;
        csr_write(3'd4, 16'h0001);
        csr_read(3'd5, rd);
        vectors++; if (rd !== 16'h0002) begin miscompares++; $display("FAIL zero_status: got %h exp 0002", rd); end
        send_frame(0);
        repeat (20) @(posedge clk); #1;
        vectors++; if (write_cycles != wc0) begin miscompares++; $display("FAIL zero_nowrite: got %0d write cycles exp 0", write_cycles - wc0); end
        csr_read(3'd7, rd);
        vectors++; if (rd !== 16'h0000) begin miscompares++; $display("FAIL zero_ovf: got %h exp 0000", rd); end
    endtask

    task automatic test_hw_reset();
        logic [15:0] rd;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        csr_read(3'd0, rd);
        vectors++; if (rd !== 16'h0000) begin miscompares++; $display("FAIL hwrst_base: got %h exp 0000", rd); end
        csr_read(3'd2, rd);
        vectors++; if (rd !== 16'h0000) begin miscompares++; $display("FAIL hwrst_step: got %h exp 0000", rd); end
        csr_read(3'd5, rd);
        vectors++; if (rd !== 16'h0000) begin miscompares++; $display("FAIL hwrst_status: got %h exp 0000", rd); end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            fr_freq[k]   = 16'(32'h0050 + 7 * k);
            fr_voiced[k] = (k % 2 == 1);
            for (int i = 0; i < 11; i++) begin
                fr_a[k][i] = 16'((k + 1) * 32'h0111 + i * 32'h0F0F + 32'h8000 * (i % 2));
            end
        end
        A0 = '0; A1 = '0; A2 = '0; A3 = '0; A4 = '0; A5 = '0;
        A6 = '0; A7 = '0; A8 = '0; A9 = '0; A10 = '0;
        voiced = 1'b0; freq_count = '0; v = 1'b0;
        addr = '0; read = 1'b0; write = 1'b0; writedata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;

        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_wrap();
        test_soft_reset();
        test_zero_limit();
        test_hw_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lpc_frame_packer.md
# lpc_frame_packer

Downstream stage of the LPC encoder. Captures each completed LPC frame (A0..A10, voiced, freq_count) on the encoder's frame-valid pulse and packs it into 13 consecutive 16-bit words. Writes those words to DDR3 through an Avalon-MM write master with a configurable base address, address step and frame count. Software controls it through a small Avalon-MM CSR slave, and the frame dump runs in parallel with the synthesis path.

## Interface
- FRAME_WORDS, 13: words per frame (fixed; not overridable in practice)
- ADDR_W, 16: DDR word-address width
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- A0..A10  in  16 each, signed  LPC coefficients from encoder
- voiced  in  1  voiced flag of frame
- freq_count  in  16  pitch period count of frame
- v  in  1  frame-valid pulse (encoder vout), one clk wide
- ddr_waitrequest  in  1  Avalon-MM stall
- ddr_addr  out  ADDR_W  write word address
- ddr_write  out  1  write request
- ddr_writedata  out  16  write data
- addr  in  3  CSR address
- read  in  1  CSR read strobe
- write  in  1  CSR write strobe
- writedata  in  16  CSR write data
- readdata  out  16  CSR read data

## Operation
- CSR map:
  - 0 base address (RW)
  - 1 frame limit N (RW)
  - 2 step (RW)
  - 3 reserved (reads 0)
  - 4 start: write bit0=1
  - 5 status (RO): bit0 busy, bit1 done
  - 6 soft reset: write bit0=1
  - 7 overflow count (RO)
- Word order per frame: w0=freq_count, w1={15'b0,voiced}, w2..w12=A0..A10.
- Two registers:
  - pending: capture buffer.
  - working: frame being written.
- On v in ARMED/WRITE:
  - pending empty, or pending promoted this cycle → capture all inputs into pending.
  - Otherwise frame dropped; overflow count +1, saturating at 0xFFFF.
- v in IDLE/DONE ignored; overflow count does not change.
- FSM:
  - IDLE → start → ARMED, clearing word index, frame count and pending. If N=0, go DONE instead.
  - ARMED: pending valid → promote to working, clear pending → WRITE.
  - WRITE: ddr_write=1. ddr_addr = base + widx·step, computed mod 2^ADDR_W (wrap silently). ddr_writedata = working word (widx mod 13).
    - Accept = ddr_write && !ddr_waitrequest. Advance widx on each accept.
    - On accept of w12, frame count +1.
    - Frame count == N → DONE.
    - Else pending valid → promote (same edge), stay WRITE.
    - Else → ARMED.
  - DONE: holds until start (re-arm) or reset.
- widx is global across frames: frame k word j sits at base + (13k+j)·step.
- Start while busy: ignored.
- Soft reset: any state → IDLE, next cycle. Drops ddr_write immediately; clears pending, counters and overflow. Keeps base/limit/step.
- rst: same as soft reset, plus all CSRs cleared to 0.

## Timing
- Reset values:
  - ddr_write=0, ddr_addr=0, ddr_writedata=0, readdata=0
  - status=0
  - overflow=0
- CSR write takes effect at the strobe edge.
- readdata is registered: valid on the cycle after the read strobe, then held until the next read.
- v at edge t → pending valid after t. If the FSM is ARMED, ddr_write rises after edge t+1.
- With no waitrequest, a frame takes exactly 13 cycles of ddr_write. Back-to-back frames produce no bubble when pending is valid at the w12 accept.
- ddr_addr, ddr_write and ddr_writedata are held stable while ddr_waitrequest=1.
- busy=1 in ARMED/WRITE; done=1 only in DONE.

## Structure
- Shared package lpc_pkg: FRAME_WORDS, CSR address constants, FSM state enum, word-index-to-field mux function.
- One sub-module, lpc_frame_packer_csr: register file, start/soft-reset pulse generation, registered readdata.
- FSM, pending/working registers and address generator live in the top module.

## Test plan
- base=0x100, step=1, N=2, two frames 240 cycles apart, no stall → 26 writes at 0x100..0x119. First word is freq_count, w12=A10. done=1, overflow=0.
- Same setup with ddr_waitrequest held high 3 cycles on every other word → identical address/data sequence; signals stable through each stall.
- N=3, three v pulses 2 cycles apart → first two frames written, third dropped, overflow reads 1. Fourth frame later completes N=3.
- base=0xFFF8, step=2, N=1 → addresses 0xFFF8, 0xFFFA, …, wrapping through 0x0000 to 0x0010.
- Soft reset mid-frame (after word 5) → ddr_write low next cycle, status=0, base/step/N unchanged. Restart produces a full frame from base.
- N=0 then start → done=1 after one cycle, no ddr_write ever asserted.
